// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control slice.
// Provides stall-vector bit indices, the canonical stall patterns and the
// sequencer state type used by pipe_ctrl.
package pipe_ctrl_pkg;

  // Bit positions inside the 6-bit stall vector (1 = hold that stage).
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  // Canonical stall patterns.
  localparam logic [5:0] STALL_VEC_MEM      = 6'b011111; // freeze everything up to MEM
  localparam logic [5:0] STALL_VEC_LOAD_USE = 6'b000111; // bubble into EX
  localparam logic [5:0] STALL_VEC_FETCH    = 6'b000011; // bubble into ID
  localparam logic [5:0] STALL_VEC_NONE     = 6'b000000;

  typedef enum logic {
    CTRL_RUN,
    CTRL_REDIR_WAIT
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector.
// Flags when the instruction in ID reads a register that the load currently
// in EX is about to write. x0 is never a hazard.
// Ports:
//   id_reg1_read_i/id_reg1_addr_i  rs1 usage and index at ID
//   id_reg2_read_i/id_reg2_addr_i  rs2 usage and index at ID
//   ex_is_load_i                   EX instruction is a load
//   ex_wd_i                        EX destination register
//   load_use_o                     1 = ID must wait one cycle
module hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = id_reg1_read_i && (id_reg1_addr_i == ex_wd_i);
    rs2_hit    = id_reg2_read_i && (id_reg2_addr_i == ex_wd_i);
    load_use_o = ex_is_load_i && (ex_wd_i != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Merges IF/MEM stall requests, ID load-use hazards and EX branch redirects
// into one stall vector plus flush/redirect controls. A redirect that arrives
// while a fetch is outstanding is parked until the fetch completes.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   if_stallreq_i   fetch not complete this cycle
//   mem_stallreq_i  data access not complete this cycle
//   id_reg*_i       ID register-read info for load-use detection
//   ex_is_load_i    EX holds a load
//   ex_wd_i         EX destination register
//   ex_branch_i     EX resolved a taken branch/jump
//   ex_target_i     redirect target from EX
//   stall_o         per-stage hold vector (bit0=pc .. bit5=wb)
//   flush_o         clear IF/ID and ID/EX this cycle
//   pc_redirect_o   PC loads new_pc_o at next edge
//   new_pc_o        redirect target
//   stall_cnt_o     cycles with any stall
//   flush_cnt_o     redirects issued
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_stallreq_i,
  input  logic                  mem_stallreq_i,
  input  logic                  id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_branch_i,
  input  logic [ADDR_W-1:0]     ex_target_i,
  output logic [5:0]            stall_o,
  output logic                  flush_o,
  output logic                  pc_redirect_o,
  output logic [ADDR_W-1:0]     new_pc_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic              load_use;
  logic [5:0]        stall_d;
  logic              flush_d;
  logic              redirect_d;
  logic [ADDR_W-1:0] new_pc_d;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wd_i        (ex_wd_i),
    .load_use_o     (load_use)
  );

  always_comb begin
    stall_d    = STALL_VEC_NONE;
    flush_d    = 1'b0;
    redirect_d = 1'b0;
    new_pc_d   = '0;
    state_d    = state_q;
    pend_d     = pend_q;

    unique case (state_q)
      CTRL_RUN: begin
        // A mem stall freezes EX too, so a branch or load-use seen now is
        // simply re-presented once the stall drops.
        if (mem_stallreq_i) begin
          stall_d = STALL_VEC_MEM;
        end else if (ex_branch_i) begin
          flush_d = 1'b1;
          if (!if_stallreq_i) begin
            redirect_d = 1'b1;
            new_pc_d   = ex_target_i;
          end else begin
            pend_d  = ex_target_i;
            state_d = CTRL_REDIR_WAIT;
          end
        end else if (load_use) begin
          stall_d = STALL_VEC_LOAD_USE;
        end else if (if_stallreq_i) begin
          stall_d = STALL_VEC_FETCH;
        end
      end

      CTRL_REDIR_WAIT: begin
        // Wrong-path instructions keep being squashed until the parked
        // target can be handed to the PC.
        flush_d = 1'b1;
        stall_d = mem_stallreq_i ? STALL_VEC_MEM : STALL_VEC_FETCH;
        if (!if_stallreq_i && !mem_stallreq_i) begin
          redirect_d = 1'b1;
          new_pc_d   = pend_q;
          state_d    = CTRL_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CTRL_RUN;
      pend_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (stall_d != STALL_VEC_NONE) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (redirect_d) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are forced quiet for the whole reset cycle, including the
  // registered counters whose cleared value only appears after the edge.
  always_comb begin
    stall_o       = rst ? STALL_VEC_NONE : stall_d;
    flush_o       = rst ? 1'b0 : flush_d;
    pc_redirect_o = rst ? 1'b0 : redirect_d;
    new_pc_o      = rst ? '0 : new_pc_d;
    stall_cnt_o   = rst ? '0 : stall_cnt_q;
    flush_cnt_o   = rst ? '0 : flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stallreq_i, mem_stallreq_i;
  logic        id_reg1_read_i, id_reg2_read_i;
  logic [4:0]  id_reg1_addr_i, id_reg2_addr_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_wd_i;
  logic        ex_branch_i;
  logic [31:0] ex_target_i;
  logic [5:0]  stall_o;
  logic        flush_o, pc_redirect_o;
  logic [31:0] new_pc_o, stall_cnt_o, flush_cnt_o;

  pipe_ctrl #(.ADDR_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_stallreq_i  (if_stallreq_i),
    .mem_stallreq_i (mem_stallreq_i),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wd_i        (ex_wd_i),
    .ex_branch_i    (ex_branch_i),
    .ex_target_i    (ex_target_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .pc_redirect_o  (pc_redirect_o),
    .new_pc_o       (new_pc_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: "a redirect is parked" flag, the parked address and
  // two plain counters.
  bit          m_parked;
  int unsigned m_parked_pc;
  int unsigned m_stalls;
  int unsigned m_redirs;

  // Last observed DUT outputs (for literal pins on a just-finished cycle).
  logic [5:0]  obs_stall;
  logic        obs_flush, obs_redir;
  logic [31:0] obs_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check all outputs against the model, then
  // advance the model across the clock edge.
  task automatic apply(input bit r, input bit ifs, input bit mems,
                       input bit r1rd, input int unsigned r1a,
                       input bit r2rd, input int unsigned r2a,
                       input bit ld, input int unsigned wd,
                       input bit br, input int unsigned tgt);
    bit          hazard, e_flush, e_redir;
    int unsigned e_stall, e_pc;
    rst = r; if_stallreq_i = ifs; mem_stallreq_i = mems;
    id_reg1_read_i = r1rd; id_reg1_addr_i = 5'(r1a);
    id_reg2_read_i = r2rd; id_reg2_addr_i = 5'(r2a);
    ex_is_load_i = ld; ex_wd_i = 5'(wd);
    ex_branch_i = br; ex_target_i = tgt;
    #2;
    hazard  = ld && wd != 0 && ((r1rd && r1a == wd) || (r2rd && r2a == wd));
    e_stall = 0; e_flush = 0; e_redir = 0; e_pc = 0;
    if (r) begin
      // everything quiet
    end else if (m_parked) begin
      e_flush = 1;
      e_stall = mems ? 'h1f : 'h03;
      if (!ifs && !mems) begin e_redir = 1; e_pc = m_parked_pc; end
    end else if (mems) e_stall = 'h1f;
    else if (br) begin
      e_flush = 1;
      if (!ifs) begin e_redir = 1; e_pc = tgt; end
    end else if (hazard) e_stall = 'h07;
    else if (ifs) e_stall = 'h03;

    chk("stall", stall_o, e_stall);
    chk("flush", flush_o, e_flush);
    chk("redirect", pc_redirect_o, e_redir);
    chk("new_pc", new_pc_o, e_pc);
    chk("stall_cnt", stall_cnt_o, r ? 0 : m_stalls);
    chk("flush_cnt", flush_cnt_o, r ? 0 : m_redirs);
    obs_stall = stall_o; obs_flush = flush_o; obs_redir = pc_redirect_o; obs_pc = new_pc_o;

    @(posedge clk);
    if (r) begin
      m_parked = 0; m_parked_pc = 0; m_stalls = 0; m_redirs = 0;
    end else begin
      if (e_stall != 0) m_stalls++;
      if (e_redir) m_redirs++;
      if (e_redir) m_parked = 0;
      else if (!m_parked && !mems && br && ifs) begin
        m_parked = 1; m_parked_pc = tgt;
      end
    end
    #1;
  endtask

  task automatic idle(input bit ifs);
    apply(0, ifs, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_parked = 0; m_parked_pc = 0; m_stalls = 0; m_redirs = 0;
    @(posedge clk); #1;

    // Reset
    apply(1, 1, 1, 1, 5, 0, 0, 1, 5, 1, 'h40);
    chk("rst_stall", obs_stall, 6'b000000);
    chk("rst_redir", obs_redir, 1'b0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_flush_cnt", flush_cnt_o, 0);

    // Load-use on rs1
    apply(0, 0, 0, 1, 5, 0, 0, 1, 5, 0, 0);
    chk("lu_stall", obs_stall, 6'b000111);
    idle(0);
    chk("lu_gone", obs_stall, 6'b000000);
    chk("lu_cnt", obs_stall == 0 ? stall_cnt_o : 32'hdead, 1);

    // Load to x0 is no hazard
    apply(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_stall", obs_stall, 6'b000000);

    // Immediate branch redirect
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h100);
    chk("br_flush", obs_flush, 1'b1);
    chk("br_redir", obs_redir, 1'b1);
    chk("br_pc", obs_pc, 32'h100);
    idle(0);
    chk("br_flush_cnt", flush_cnt_o, 1);

    // Branch while fetch outstanding for 3 cycles
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h200);
    chk("pend0_redir", obs_redir, 1'b0);
    chk("pend0_flush", obs_flush, 1'b1);
    idle(1);
    chk("pend1_stall", obs_stall, 6'b000011);
    idle(1);
    chk("pend2_flush", obs_flush, 1'b1);
    idle(0);
    chk("pend_redir", obs_redir, 1'b1);
    chk("pend_pc", obs_pc, 32'h200);

    // Mem stall masks a branch; redirect once it drops
    apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 'h300);
    chk("mem_stall", obs_stall, 6'b011111);
    chk("mem_noflush", obs_flush, 1'b0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h300);
    chk("mem_redir_pc", obs_pc, 32'h300);

    // Reset while a redirect is parked
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h400);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstw_flush", obs_flush, 1'b0);
    idle(0);
    chk("rstw_noredir", obs_redir, 1'b0);
    chk("rstw_nostall", obs_stall, 6'b000000);
    idle(0);
    chk("rstw_noredir2", obs_redir, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 20,
            $urandom_range(1), $urandom_range(3), $urandom_range(1), $urandom_range(3),
            $urandom_range(99) < 40, $urandom_range(3),
            $urandom_range(99) < 20, $urandom & 32'hfffffffc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
